// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit 7-segment scan driver with blank gaps between digits.
// New values are double-buffered and take effect only at a frame start, so a frame never mixes two values.
module seg7_scan_driver #(
  parameter int SLOT_CYCLES  = 10000,
  parameter int BLANK_CYCLES = 64
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        en_i,
  input  logic        load_i,
  input  logic [15:0] bcd_i,
  input  logic [3:0]  dp_i,
  input  logic        lzb_i,
  output logic [7:0]  seven_seg,
  output logic [3:0]  digit_en,
  output logic        frame_o
);

  localparam int CNT_MAX = (SLOT_CYCLES > BLANK_CYCLES) ? SLOT_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [1:0]       r_idx;
  logic [1:0]       w_idx_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_frame_start;

  logic [15:0]      r_sh_bcd;
  logic [3:0]       r_sh_dp;
  logic             r_sh_lzb;
  logic [15:0]      r_act_bcd;
  logic [3:0]       r_act_dp;
  logic             r_act_lzb;

  logic [7:0]       w_seg [4];
  logic [7:0]       w_seg_next;
  logic [3:0]       w_digit_next;

  function automatic logic [6:0] f_encode(input logic [3:0] i_nib);
    case (i_nib)
      4'd0:    f_encode = 7'h3F;
      4'd1:    f_encode = 7'h06;
      4'd2:    f_encode = 7'h5B;
      4'd3:    f_encode = 7'h4F;
      4'd4:    f_encode = 7'h66;
      4'd5:    f_encode = 7'h6D;
      4'd6:    f_encode = 7'h7D;
      4'd7:    f_encode = 7'h07;
      4'd8:    f_encode = 7'h7F;
      4'd9:    f_encode = 7'h6F;
      default: f_encode = 7'h40;
    endcase
  endfunction

  // Per-digit segment pattern from the active register; units digit is never blanked.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      logic [6:0] w_glyph;
      assign w_glyph = f_encode(r_act_bcd[gi*4 +: 4]);
      if (gi == 0) begin : g_units
        assign w_seg[gi] = {r_act_dp[gi], w_glyph};
      end else begin : g_upper
        logic w_lz;
        assign w_lz       = r_act_lzb && (r_act_bcd[15:gi*4] == '0);
        assign w_seg[gi]  = {r_act_dp[gi], (w_lz ? 7'h00 : w_glyph)};
      end
    end
  endgenerate

  always_comb begin
    w_state_next  = r_state;
    w_idx_next    = r_idx;
    w_cnt_next    = r_cnt;
    w_frame_start = 1'b0;
    if (!en_i) begin
      w_state_next = ST_IDLE;
      w_idx_next   = 2'd0;
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_next  = ST_BLANK;
          w_idx_next    = 2'd0;
          w_cnt_next    = '0;
          w_frame_start = 1'b1;
        end
        ST_BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            w_state_next = ST_DRIVE;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end
        ST_DRIVE: begin
          if (r_cnt == SLOT_LAST) begin
            w_state_next  = ST_BLANK;
            w_idx_next    = r_idx + 2'd1;
            w_cnt_next    = '0;
            w_frame_start = (r_idx == 2'd3);
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_next = ST_IDLE;
          w_idx_next   = 2'd0;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with it cycle for cycle.
  assign w_digit_next = 4'b0001 << w_idx_next;
  assign w_seg_next   = w_seg[w_idx_next];

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state   <= ST_IDLE;
      r_idx     <= 2'd0;
      r_cnt     <= '0;
      r_sh_bcd  <= '0;
      r_sh_dp   <= '0;
      r_sh_lzb  <= 1'b0;
      r_act_bcd <= '0;
      r_act_dp  <= '0;
      r_act_lzb <= 1'b0;
      seven_seg <= '0;
      digit_en  <= '0;
      frame_o   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_cnt   <= w_cnt_next;
      if (load_i) begin
        r_sh_bcd <= bcd_i;
        r_sh_dp  <= dp_i;
        r_sh_lzb <= lzb_i;
      end
      if (w_frame_start) begin
        r_act_bcd <= r_sh_bcd;
        r_act_dp  <= r_sh_dp;
        r_act_lzb <= r_sh_lzb;
      end
      frame_o   <= w_frame_start;
      digit_en  <= (w_state_next == ST_DRIVE) ? w_digit_next : 4'b0000;
      seven_seg <= (w_state_next == ST_DRIVE) ? w_seg_next : 8'h00;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomised and directed bench for seg7_scan_driver against a frame-position model.
// The model places each cycle within the frame by arithmetic and derives the expected pads from that.
module tb_seg7_scan_driver;

  localparam int S     = 4;
  localparam int B     = 2;
  localparam int SLOT  = S + B;
  localparam int FRAME = 4 * SLOT;

  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40
  };

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] bcd;
  logic [3:0]  dp;
  logic        lzb;
  logic [7:0]  seven_seg;
  logic [3:0]  digit_en;
  logic        frame_o;

  int n_vec  = 0;
  int n_miss = 0;

  // model state
  bit          m_run;
  int          m_p;
  logic [15:0] sh_bcd, ac_bcd;
  logic [3:0]  sh_dp, ac_dp;
  logic        sh_lzb, ac_lzb;

  logic [7:0]  cap [4];
  logic [3:0]  last_de = 4'b0000;
  int          z_run = 0;

  seg7_scan_driver #(.SLOT_CYCLES(S), .BLANK_CYCLES(B)) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .en_i     (en),
    .load_i   (load),
    .bcd_i    (bcd),
    .dp_i     (dp),
    .lzb_i    (lzb),
    .seven_seg(seven_seg),
    .digit_en (digit_en),
    .frame_o  (frame_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run  = 1'b0;
    m_p    = 0;
    sh_bcd = '0; sh_dp = '0; sh_lzb = 1'b0;
    ac_bcd = '0; ac_dp = '0; ac_lzb = 1'b0;
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (en) begin
      if (!m_run) begin
        m_run = 1'b1;
        m_p   = 0;
      end else begin
        m_p = (m_p + 1) % FRAME;
      end
      if (m_p == 0) begin
        ac_bcd = sh_bcd; ac_dp = sh_dp; ac_lzb = sh_lzb;
      end
    end else begin
      m_run = 1'b0;
      m_p   = 0;
    end
    if (load) begin
      sh_bcd = bcd; sh_dp = dp; sh_lzb = lzb;
    end
  endtask

  function automatic logic [7:0] digit_seg(input int k);
    logic [3:0]  nib;
    logic [15:0] upper;
    logic [6:0]  g;
    nib   = 4'((ac_bcd >> (4 * k)) & 16'hF);
    upper = ac_bcd >> (4 * k);
    g     = GLYPH[nib];
    if (ac_lzb && k > 0 && upper == 16'h0) g = 7'h00;
    return {ac_dp[k], g};
  endfunction

  task automatic check_all();
    logic [3:0] e_de;
    logic [7:0] e_seg;
    logic       e_fr;
    int         slot;
    e_de = 4'b0; e_seg = 8'h00; e_fr = 1'b0;
    if (m_run) begin
      slot = m_p / SLOT;
      e_fr = (m_p == 0);
      if ((m_p % SLOT) >= B) begin
        e_de  = 4'(1 << slot);
        e_seg = digit_seg(slot);
      end
    end
    chk("digit_en", {28'b0, digit_en}, {28'b0, e_de});
    chk("seven_seg", {24'b0, seven_seg}, {24'b0, e_seg});
    chk("frame_o", {31'b0, frame_o}, {31'b0, e_fr});
    chk("onehot", {31'b0, ($countones(digit_en) <= 1)}, 32'd1);
    if (digit_en == 4'b0) begin
      z_run++;
    end else begin
      if (last_de != 4'b0 && digit_en != last_de)
        chk("blank_gap", {31'b0, (z_run >= B)}, 32'd1);
      last_de = digit_en;
      z_run   = 0;
      case (digit_en)
        4'b0001: cap[0] = seven_seg;
        4'b0010: cap[1] = seven_seg;
        4'b0100: cap[2] = seven_seg;
        4'b1000: cap[3] = seven_seg;
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic clear_cap();
    for (int i = 0; i < 4; i++) cap[i] = 8'hEE;
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic z);
    $display("load bcd=%h dp=%b lzb=%b en=%b", v, d, z, en);
    bcd = v; dp = d; lzb = z; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_frame();
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (m_run && m_p == 0) break;
    end
    chk("frame_align", m_p, 0);
  endtask

  task automatic ticks_to(input int target);
    for (int i = 0; i < 2 * FRAME && m_p != target; i++) tick();
    chk("pos_align", m_p, target);
  endtask

  task automatic show_frame(input string tag, input logic [7:0] d3, input logic [7:0] d2,
                            input logic [7:0] d1, input logic [7:0] d0);
    wait_frame();
    clear_cap();
    repeat (FRAME) tick();
    chk({tag, "_d3"}, {24'b0, cap[3]}, {24'b0, d3});
    chk({tag, "_d2"}, {24'b0, cap[2]}, {24'b0, d2});
    chk({tag, "_d1"}, {24'b0, cap[1]}, {24'b0, d1});
    chk({tag, "_d0"}, {24'b0, cap[0]}, {24'b0, d0});
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; en = 1'b0; load = 1'b0; bcd = '0; dp = '0; lzb = 1'b0;
    model_reset();
    clear_cap();

    // reset and basic scan
    repeat (2) tick();
    chk("rst_seg", {24'b0, seven_seg}, 32'h0);
    chk("rst_de", {28'b0, digit_en}, 32'h0);
    #3 rst_n = 1'b1;
    tick();
    do_load(16'h1234, 4'b0000, 1'b0);
    en = 1'b1;
    tick();
    chk("start_frame", {31'b0, frame_o}, 32'd1);
    chk("start_blank", {28'b0, digit_en}, 32'h0);
    tick();
    chk("blank2", {28'b0, digit_en}, 32'h0);
    tick();
    chk("first_digit", {28'b0, digit_en}, 32'h1);
    chk("first_seg", {24'b0, seven_seg}, 32'h66);
    wait_frame();
    cnt = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      cnt++;
      if (frame_o) break;
    end
    chk("frame_period", cnt, FRAME);
    show_frame("s1", 8'h06, 8'h5B, 8'h4F, 8'h66);

    // tear-free update mid digit 1
    wait_frame();
    ticks_to(9);
    clear_cap();
    do_load(16'h5678, 4'b0000, 1'b0);
    ticks_to(FRAME - 1);
    chk("tear_d2", {24'b0, cap[2]}, 32'h5B);
    chk("tear_d3", {24'b0, cap[3]}, 32'h06);
    clear_cap();
    repeat (FRAME) tick();
    chk("upd_d0", {24'b0, cap[0]}, 32'h7F);
    chk("upd_d1", {24'b0, cap[1]}, 32'h07);
    chk("upd_d2", {24'b0, cap[2]}, 32'h7D);
    chk("upd_d3", {24'b0, cap[3]}, 32'h6D);

    // load on the frame-start edge shows one frame later
    ticks_to(FRAME - 1);
    do_load(16'h4321, 4'b0000, 1'b0);
    chk("edge_frame", {31'b0, frame_o}, 32'd1);
    clear_cap();
    repeat (FRAME - 1) tick();
    chk("edge_old_d0", {24'b0, cap[0]}, 32'h7F);
    clear_cap();
    repeat (FRAME) tick();
    chk("edge_new_d0", {24'b0, cap[0]}, 32'h06);

    // leading-zero blanking
    do_load(16'h0007, 4'b0100, 1'b1);
    show_frame("lzb", 8'h00, 8'h80, 8'h00, 8'h07);
    do_load(16'h0000, 4'b0000, 1'b1);
    show_frame("lzb0", 8'h00, 8'h00, 8'h00, 8'h3F);

    // invalid BCD
    do_load(16'hA0F9, 4'b0000, 1'b1);
    show_frame("inv", 8'h40, 8'h3F, 8'h40, 8'h6F);

    // disable during DRIVE, re-enable, async reset
    wait_frame();
    ticks_to(3);
    en = 1'b0;
    tick();
    chk("dis_de", {28'b0, digit_en}, 32'h0);
    chk("dis_seg", {24'b0, seven_seg}, 32'h0);
    tick();
    en = 1'b1;
    tick();
    chk("reen_frame", {31'b0, frame_o}, 32'd1);
    clear_cap();
    repeat (FRAME - 1) tick();
    chk("reen_d3", {24'b0, cap[3]}, 32'h40);
    chk("reen_d0", {24'b0, cap[0]}, 32'h6F);
    ticks_to(4);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_de", {28'b0, digit_en}, 32'h0);
    chk("arst_seg", {24'b0, seven_seg}, 32'h0);
    chk("arst_fr", {31'b0, frame_o}, 32'h0);
    tick();
    #3 rst_n = 1'b1;
    show_frame("post_rst", 8'h3F, 8'h3F, 8'h3F, 8'h3F);

    // randomised load / enable traffic
    for (int i = 0; i < 10000; i++) begin
      en   = ($urandom_range(0, 199) != 0);
      load = ($urandom_range(0, 19) == 0);
      bcd  = 16'($urandom);
      if ($urandom_range(0, 1) == 1) bcd = bcd & 16'h00FF;
      dp   = 4'($urandom);
      lzb  = 1'($urandom);
      tick();
    end
    load = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
